// File: rtl/syst_ws_pkg.sv
// Shared types for the systolic-array result collector: default widths and
// the packed FIFO entry (sum field present only with SYST_WS_COLL_SUM_EN).
package syst_ws_pkg;

   localparam int SYST_WS_DATA_W = 19;
   localparam int SYST_WS_IDX_W  = 16;

   typedef struct packed {
      logic [SYST_WS_DATA_W-1:0] y1;
      logic [SYST_WS_DATA_W-1:0] y2;
      logic [SYST_WS_IDX_W-1:0]  idx;
`ifdef SYST_WS_COLL_SUM_EN
      logic [SYST_WS_DATA_W:0]   sum;
`endif
   } syst_ws_res_t;

endpackage

// File: rtl/syst_ws_res_fifo.sv
// Synchronous FIFO of syst_ws_res_t entries; pointers carry an extra MSB.
// Ports: clk_i, rst_i (async high), push_i, pop_i, din_i, dout_o (0 when
// empty), full_o, empty_o, count_o (0..DEPTH).
module syst_ws_res_fifo
   import syst_ws_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  syst_ws_res_t            din_i,
   output syst_ws_res_t            dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);

   syst_ws_res_t mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign count_o = wr_q - rd_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/syst_ws_collector.sv
// Output collector for the 2x3 weight-stationary array: tracks validity from
// x_valid_i, deskews y1/y2, tags results with an index and buffers them.
// Ports: clk_i, rst_i (async high), x_valid_i, y1_i, y2_i, res_valid_o,
// res_ready_i, res_y1_o, res_y2_o, res_idx_o, fill_o, overflow_o, and
// res_sum_o (y1+y2) when SYST_WS_COLL_SUM_EN is defined.
module syst_ws_collector
   import syst_ws_pkg::*;
#(
   parameter int DATA_W     = SYST_WS_DATA_W,
   parameter int LAT        = 3,
   parameter int SKEW       = 1,
   parameter int FIFO_DEPTH = 8,
   parameter int IDX_W      = SYST_WS_IDX_W
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          x_valid_i,
   input  logic [DATA_W-1:0]             y1_i,
   input  logic [DATA_W-1:0]             y2_i,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [DATA_W-1:0]             res_y1_o,
   output logic [DATA_W-1:0]             res_y2_o,
   output logic [IDX_W-1:0]              res_idx_o,
   output logic [$clog2(FIFO_DEPTH):0]   fill_o,
`ifdef SYST_WS_COLL_SUM_EN
   output logic [DATA_W:0]               res_sum_o,
`endif
   output logic                          overflow_o
);

   localparam int DLY = LAT + SKEW;

   logic [DLY-1:0]    vld_q, vld_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] y1_dly;
   logic              push;
   logic              full;
   logic              empty;
   syst_ws_res_t      ent;
   syst_ws_res_t      head;

   // Validity shift register: the last tap lines up with y2 at the array.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = x_valid_i;
      for (int i = 1; i < DLY; i++) vld_d[i] = vld_q[i-1];
   end

   assign push = vld_q[DLY-1];

   // y1 leaves the array SKEW cycles ahead of y2, so hold it back.
   if (SKEW == 0) begin : g_noskew
      assign y1_dly = y1_i;
   end else begin : g_skew
      logic [DATA_W-1:0] sk_q [SKEW];
      logic [DATA_W-1:0] sk_d [SKEW];

      always_comb begin
         sk_d[0] = y1_i;
         for (int i = 1; i < SKEW; i++) sk_d[i] = sk_q[i-1];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int i = 0; i < SKEW; i++) sk_q[i] <= '0;
         end else begin
            for (int i = 0; i < SKEW; i++) sk_q[i] <= sk_d[i];
         end
      end

      assign y1_dly = sk_q[SKEW-1];
   end

   always_comb begin
      ent     = '0;
      ent.y1  = y1_dly;
      ent.y2  = y2_i;
      ent.idx = idx_q;
`ifdef SYST_WS_COLL_SUM_EN
      ent.sum = {1'b0, y1_dly} + {1'b0, y2_i};
`endif
   end

   // The index advances even for dropped entries so gaps show downstream.
   always_comb begin
      idx_d = idx_q;
      ovf_d = ovf_q;
      if (push) idx_d = idx_q + 1'b1;
      if (push && full && !(res_ready_i && !empty)) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         idx_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
         ovf_q <= ovf_d;
      end
   end

   syst_ws_res_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (res_ready_i),
      .din_i   (ent),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fill_o)
   );

   assign res_valid_o = !empty;
   assign res_y1_o    = head.y1;
   assign res_y2_o    = head.y2;
   assign res_idx_o   = head.idx;
   assign overflow_o  = ovf_q;
`ifdef SYST_WS_COLL_SUM_EN
   assign res_sum_o   = head.sum;
`endif

endmodule

// File: tb/tb_syst_ws_collector.sv
// Directed bench for syst_ws_collector (LAT=3, SKEW=1, depth 8).
// Optional sum checks follow SYST_WS_COLL_SUM_EN.
module tb_syst_ws_collector;

   localparam int DW = 19;
   localparam int IW = 16;
   localparam int FW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          x_valid_i;
   logic [DW-1:0] y1_i;
   logic [DW-1:0] y2_i;
   logic          res_valid_o;
   logic          res_ready_i;
   logic [DW-1:0] res_y1_o;
   logic [DW-1:0] res_y2_o;
   logic [IW-1:0] res_idx_o;
   logic [FW-1:0] fill_o;
   logic          overflow_o;
`ifdef SYST_WS_COLL_SUM_EN
   logic [DW:0]   res_sum_o;
`endif

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int ts;
   int t;
   bit manual = 1'b1;

   syst_ws_collector #(
      .DATA_W     (DW),
      .LAT        (3),
      .SKEW       (1),
      .FIFO_DEPTH (8),
      .IDX_W      (IW)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .x_valid_i   (x_valid_i),
      .y1_i        (y1_i),
      .y2_i        (y2_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_y1_o    (res_y1_o),
      .res_y2_o    (res_y2_o),
      .res_idx_o   (res_idx_o),
      .fill_o      (fill_o),
`ifdef SYST_WS_COLL_SUM_EN
      .res_sum_o   (res_sum_o),
`endif
      .overflow_o  (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [DW-1:0] f1(input int c);
      return DW'(c * 3 + 1);
   endfunction

   function automatic logic [DW-1:0] f2(input int c);
      return DW'(c * 7 + 2);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
      if (!manual) begin
         y1_i = f1(cyc);
         y2_i = f2(cyc);
      end
   endtask

   task automatic do_reset();
      x_valid_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   initial begin
      rst_i       = 1'b1;
      x_valid_i   = 1'b0;
      y1_i        = '0;
      y2_i        = '0;
      res_ready_i = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(res_valid_o), 64'(0));
      chk("rst_fill", 64'(fill_o), 64'(0));
      chk("rst_ovf", 64'(overflow_o), 64'(0));
      rst_i = 1'b0;
      tick();

      // Load one stalled result, then reset asynchronously mid-cycle.
      res_ready_i = 1'b0;
      x_valid_i = 1'b1;
      tick();
      x_valid_i = 1'b0;
      tick();
      tick();
      y1_i = 19'd11;
      tick();
      y1_i = '0;
      y2_i = 19'd13;
      tick();
      y2_i = '0;
      chk("pre_valid", 64'(res_valid_o), 64'(1));
      chk("pre_y1", 64'(res_y1_o), 64'(11));
      #3;
      rst_i = 1'b1;
      res_ready_i = 1'b1;
      #1;
      chk("arst_valid", 64'(res_valid_o), 64'(0));
      chk("arst_y1", 64'(res_y1_o), 64'(0));
      chk("arst_y2", 64'(res_y2_o), 64'(0));
      chk("arst_idx", 64'(res_idx_o), 64'(0));
      chk("arst_fill", 64'(fill_o), 64'(0));
      chk("arst_ovf", 64'(overflow_o), 64'(0));
      tick();
      rst_i = 1'b0;
      tick();

      // Single pulse: y1=5 at t+3, y2=7 at t+4, result at t+5.
      x_valid_i = 1'b1;
      tick();
      x_valid_i = 1'b0;
      tick();
      tick();
      y1_i = 19'd5;
      tick();
      y1_i = '0;
      y2_i = 19'd7;
      chk("t1_early", 64'(res_valid_o), 64'(0));
      tick();
      y2_i = '0;
      chk("t1_valid", 64'(res_valid_o), 64'(1));
      chk("t1_y1", 64'(res_y1_o), 64'(5));
      chk("t1_y2", 64'(res_y2_o), 64'(7));
      chk("t1_idx", 64'(res_idx_o), 64'(0));
      tick();
      chk("t1_pop", 64'(res_valid_o), 64'(0));
      chk("t1_fill", 64'(fill_o), 64'(0));

      // 20 back-to-back valids, downstream always ready.
      do_reset();
      manual = 1'b0;
      y1_i = f1(cyc);
      y2_i = f2(cyc);
      res_ready_i = 1'b1;
      ts = cyc;
      for (int c = 0; c < 27; c++) begin
         x_valid_i = (c < 20);
         if (c >= 5 && c < 25) begin
            chk("t2_valid", 64'(res_valid_o), 64'(1));
            chk("t2_y1", 64'(res_y1_o), 64'(f1(ts + c - 2)));
            chk("t2_y2", 64'(res_y2_o), 64'(f2(ts + c - 1)));
            chk("t2_idx", 64'(res_idx_o), 64'(c - 5));
         end else begin
            chk("t2_idle", 64'(res_valid_o), 64'(0));
         end
         chk("t2_fill", 64'(fill_o <= 4'd1), 64'(1));
         tick();
      end
      chk("t2_ovf", 64'(overflow_o), 64'(0));

      // Stalled output, 10 valids: idx 8 and 9 dropped.
      do_reset();
      res_ready_i = 1'b0;
      ts = cyc;
      for (int c = 0; c < 14; c++) begin
         x_valid_i = (c < 10);
         tick();
      end
      chk("t3_fill", 64'(fill_o), 64'(8));
      chk("t3_ovf", 64'(overflow_o), 64'(1));
      res_ready_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("t3_valid", 64'(res_valid_o), 64'(1));
         chk("t3_idx", 64'(res_idx_o), 64'(k));
         chk("t3_y1", 64'(res_y1_o), 64'(f1(ts + k + 3)));
         tick();
      end
      chk("t3_empty", 64'(res_valid_o), 64'(0));
      chk("t3_fill0", 64'(fill_o), 64'(0));
      chk("t3_ovf_sticky", 64'(overflow_o), 64'(1));
      x_valid_i = 1'b1;
      tick();
      x_valid_i = 1'b0;
      repeat (4) tick();
      chk("t3_gap_idx", 64'(res_idx_o), 64'(10));

      // Full FIFO with ready=1 during a stream: push and pop together.
      do_reset();
      res_ready_i = 1'b0;
      ts = cyc;
      for (int c = 0; c < 28; c++) begin
         x_valid_i = (c < 20);
         res_ready_i = (c >= 12);
         if (c >= 12 && c <= 24) begin
            chk("t4_fill", 64'(fill_o), 64'(8));
            chk("t4_idx", 64'(res_idx_o), 64'(c - 12));
            chk("t4_ovf", 64'(overflow_o), 64'(0));
         end
         if (c == 25) chk("t4_fill7", 64'(fill_o), 64'(7));
         tick();
      end

      // Reset with 4 buffered and 3 in flight.
      do_reset();
      res_ready_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         x_valid_i = (c < 7);
         tick();
      end
      chk("t5_fill4", 64'(fill_o), 64'(4));
      #3;
      rst_i = 1'b1;
      res_ready_i = 1'b1;
      x_valid_i = 1'b0;
      #1;
      chk("t5_arst_fill", 64'(fill_o), 64'(0));
      tick();
      rst_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk("t5_quiet", 64'(res_valid_o), 64'(0));
         tick();
      end
      t = cyc;
      x_valid_i = 1'b1;
      tick();
      x_valid_i = 1'b0;
      repeat (3) tick();
      chk("t5_early", 64'(res_valid_o), 64'(0));
      tick();
      chk("t5_valid", 64'(res_valid_o), 64'(1));
      chk("t5_idx", 64'(res_idx_o), 64'(0));
      chk("t5_y1", 64'(res_y1_o), 64'(f1(t + 3)));
      chk("t5_y2", 64'(res_y2_o), 64'(f2(t + 4)));

      // Max-value operands, stalled output holds every field.
      do_reset();
      manual = 1'b1;
      y1_i = '0;
      y2_i = '0;
      res_ready_i = 1'b0;
      x_valid_i = 1'b1;
      tick();
      x_valid_i = 1'b0;
      tick();
      tick();
      y1_i = 19'h7FFFF;
      tick();
      y1_i = '0;
      y2_i = 19'h7FFFF;
      tick();
      y2_i = '0;
      for (int h = 0; h < 4; h++) begin
         chk("t6_valid", 64'(res_valid_o), 64'(1));
         chk("t6_y1", 64'(res_y1_o), 64'(19'h7FFFF));
         chk("t6_y2", 64'(res_y2_o), 64'(19'h7FFFF));
         chk("t6_idx", 64'(res_idx_o), 64'(0));
`ifdef SYST_WS_COLL_SUM_EN
         chk("t6_sum", 64'(res_sum_o), 64'(20'hFFFFE));
`endif
         tick();
      end
      res_ready_i = 1'b1;
      tick();
      chk("t6_empty", 64'(res_valid_o), 64'(0));
      chk("t6_y1_zero", 64'(res_y1_o), 64'(0));
      chk("t6_y2_zero", 64'(res_y2_o), 64'(0));
`ifdef SYST_WS_COLL_SUM_EN
      chk("t6_sum_zero", 64'(res_sum_o), 64'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
